loop_sampler_ctrl: RTL and testbench
====================================

// Module: loop_sampler_ctrl
// PURPOSE
//  Sequences a bank of NUM_LOOPS free-running inverter ring oscillators that share one ctrl/seed pair.
//  Each round it seeds the loops, releases them to run, then samples and synchronizes their outputs.
//  It XOR-reduces the samples into one raw bit and packs the bits into WORD_BITS-wide words.
//  Sits between the oscillator bank and the entropy consumer, which reads words over a valid/ack handshake.
// PARAMETERS
//  NUM_LOOPS    4    number of oscillator loops driven and sampled (>=1)
//  SEED_CYCLES  4    cycles the loops are held in seed mode each round (>=1)
//  RUN_CYCLES   16   cycles the loops free-run before sampling (>=3, covers 2-flop sync)
//  WORD_BITS    32   raw bits per output word (>=2)
//  REP_LIMIT    32   consecutive identical raw bits that trip the health error (>=2)
// PORTS
//  clk        in   1          system clock
//  reset      in   1          synchronous, active-high reset
//  enable     in   1          1 = generate words; 0 = park loops in IDLE
//  ack        in   1          consumer accepts data; valid only while valid=1
//  loop_d     in   NUM_LOOPS  asynchronous outputs of the oscillator loops
//  loop_ctrl  out  1          1 = loops held in seed mode, 0 = loops free-run
//  loop_seed  out  1          seed value applied while loop_ctrl=1
//  data       out  WORD_BITS  assembled raw word, stable while valid=1
//  valid      out  1          data holds a complete word
//  busy       out  1          FSM not in IDLE
//  error      out  1          sticky health failure (see CONFIGURATION)
// BEHAVIOUR
//  One clock, synchronous active-high reset. Reset values: loop_ctrl=1, loop_seed=0, data=0, valid=0, busy=0, error=0.
//  Reset also clears the sync flops, counters and seed toggle. Reset mid-operation aborts at once; no partial word survives.
//  loop_d passes through a 2-flop synchronizer per bit, always enabled. Call the output sync_d.
//  FSM states: IDLE, SEED, RUN, SAMPLE, DELIVER.
//  - IDLE: loop_ctrl=1. If enable=1, go to SEED next cycle, clear bit_cnt, clear data.
//  - SEED: loop_ctrl=1 and loop_seed=seed_tgl for exactly SEED_CYCLES cycles, then go to RUN.
//  - RUN: loop_ctrl=0 for exactly RUN_CYCLES cycles, then go to SAMPLE.
//  - SAMPLE (1 cycle): loop_ctrl=0. raw = ^sync_d. data <= {data[WORD_BITS-2:0], raw}; the new bit enters the LSB.
//    seed_tgl inverts. If bit_cnt==WORD_BITS-1, go to DELIVER and set valid=1; else bit_cnt++ and go to SEED.
//  - DELIVER: loop_ctrl=1 and data/valid are held. On ack=1, clear valid; next state is SEED if enable=1, else IDLE.
//  One round takes SEED_CYCLES+RUN_CYCLES+1 cycles. valid rises 1 cycle after the final SAMPLE.
//  enable=0 in SEED, RUN or SAMPLE: go to IDLE next cycle. The partial word and bit_cnt are discarded; valid stays 0.
//  enable=0 in DELIVER: no effect until ack, so a completed word is never dropped.
//  Only one word is buffered. No new round starts while valid=1.
//  ack while valid=0 is ignored.
//  busy = (state != IDLE), registered from the state.
//  Counters: cyc_cnt is $clog2(max(SEED_CYCLES,RUN_CYCLES)+1) bits, reloaded at each state entry.
//  bit_cnt is $clog2(WORD_BITS) bits and never wraps past WORD_BITS-1.
// CONFIGURATION
//  Macro LOOP_SAMPLER_HEALTH_EN.
//  Defined:
//  - rep_cnt counts consecutive equal raw bits across words; it resets to 1 on a change.
//  - When rep_cnt reaches REP_LIMIT in SAMPLE, error is set (sticky until reset) and the FSM goes to IDLE.
//  - The partial word is discarded. With error=1 the FSM stays in IDLE regardless of enable.
//  Not defined: the repetition logic is absent, error is tied 0, and REP_LIMIT is unused.
// STRUCTURE
//  Shared package loop_ctrl_pkg: FSM state encodings (3-bit localparams) and the sync depth constant (2).
//  Sub-module loop_sync: NUM_LOOPS-wide 2-flop synchronizer with synchronous reset. All other logic is in this module.
// TESTING (NUM_LOOPS=2, SEED_CYCLES=2, RUN_CYCLES=4, WORD_BITS=8, REP_LIMIT=4)
//  1. Reset, then enable=1 with loops modelled as toggling: loop_ctrl=1 for 2 cycles, 0 for 5; valid rises 56 cycles after start (8 rounds of 7 cycles).
//  2. Model loop_d=2'b10 for every round: raw=1, data=8'hFF, valid held until ack; ack -> valid=0 and the next SEED starts.
//  3. Drop enable during RUN of bit 3: IDLE next cycle, loop_ctrl=1, valid stays 0; re-enable -> new word starts with bit_cnt=0.
//  4. Drop enable while valid=1 and ack=0: data/valid held; ack -> IDLE, busy=0.
//  5. Assert reset during RUN: next cycle all outputs are at reset values and the state is IDLE.
//  6. With LOOP_SAMPLER_HEALTH_EN, model loop_d=2'b11: raw=0 four times -> error=1, IDLE, valid never rises; without the macro, error=0 and data=8'h00 is delivered.

Source files
------------

// File: rtl/loop_ctrl_pkg.sv
// Shared definitions for the loop sampler: FSM state encodings and synchronizer depth.
package loop_ctrl_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SEED    = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_SAMPLE  = 3'd3;
    localparam logic [2:0] ST_DELIVER = 3'd4;

    localparam int unsigned SYNC_DEPTH = 2;

    typedef enum logic [2:0] {
        StIdle    = ST_IDLE,
        StSeed    = ST_SEED,
        StRun     = ST_RUN,
        StSample  = ST_SAMPLE,
        StDeliver = ST_DELIVER
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/loop_sync.sv
// Multi-bit flop-chain synchronizer for the asynchronous oscillator outputs.
module loop_sync
    import loop_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [SYNC_DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < SYNC_DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[SYNC_DEPTH-1];

endmodule

// File: rtl/loop_sampler_ctrl.sv
// Seeds, runs and samples a bank of ring oscillators and packs XOR-reduced bits into words.
// Optional repetition-count health test enabled by defining LOOP_SAMPLER_HEALTH_EN.
module loop_sampler_ctrl
    import loop_ctrl_pkg::*;
#(
    parameter int unsigned NUM_LOOPS   = 4,
    parameter int unsigned SEED_CYCLES = 4,
    parameter int unsigned RUN_CYCLES  = 16,
    parameter int unsigned WORD_BITS   = 32,
    parameter int unsigned REP_LIMIT   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 ack,
    input  logic [NUM_LOOPS-1:0] loop_d,
    output logic                 loop_ctrl,
    output logic                 loop_seed,
    output logic [WORD_BITS-1:0] data,
    output logic                 valid,
    output logic                 busy,
    output logic                 error
);

    localparam int unsigned CYC_W = $clog2(max_u(SEED_CYCLES, RUN_CYCLES) + 1);
    localparam int unsigned BIT_W = $clog2(WORD_BITS);

    localparam logic [CYC_W-1:0] SEED_LOAD = CYC_W'(SEED_CYCLES - 1);
    localparam logic [CYC_W-1:0] RUN_LOAD  = CYC_W'(RUN_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_BITS - 1);

    state_e               state;
    logic [CYC_W-1:0]     cyc_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 seed_tgl;
    logic [NUM_LOOPS-1:0] sync_d;
    logic                 raw;
    logic                 health_trip;

    loop_sync #(
        .WIDTH (NUM_LOOPS)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (loop_d),
        .q     (sync_d)
    );

    assign raw = ^sync_d;

`ifdef LOOP_SAMPLER_HEALTH_EN
    localparam int unsigned REP_W = $clog2(REP_LIMIT + 1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REP_LIMIT);

    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_nxt;
    logic             last_raw;

    // rep_cnt==0 only right after reset, so the first bit always starts a new run
    always_comb begin
        rep_nxt = REP_W'(1);
        if (rep_cnt != '0 && raw == last_raw) begin
            rep_nxt = (rep_cnt == REP_MAX) ? rep_cnt : rep_cnt + 1'b1;
        end
        health_trip = (rep_nxt == REP_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cnt  <= '0;
            last_raw <= 1'b0;
            error    <= 1'b0;
        end else if (state == StSample && enable) begin
            rep_cnt  <= rep_nxt;
            last_raw <= raw;
            if (health_trip) begin
                error <= 1'b1;
            end
        end
    end
`else
    logic unused_rep_limit;
    assign unused_rep_limit = (REP_LIMIT == 0);
    assign health_trip      = 1'b0;
    assign error            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            seed_tgl  <= 1'b0;
            data      <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            loop_ctrl <= 1'b1;
            loop_seed <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (enable && !error) begin
                        state     <= StSeed;
                        cyc_cnt   <= SEED_LOAD;
                        bit_cnt   <= '0;
                        data      <= '0;
                        busy      <= 1'b1;
                        loop_ctrl <= 1'b1;
                        loop_seed <= seed_tgl;
                    end
                end

                StSeed: begin
                    if (!enable) begin
                        state     <= StIdle;
                        bit_cnt   <= '0;
                        data      <= '0;
                        busy      <= 1'b0;
                        loop_ctrl <= 1'b1;
                    end else if (cyc_cnt == '0) begin
                        state     <= StRun;
                        cyc_cnt   <= RUN_LOAD;
                        loop_ctrl <= 1'b0;
                    end else begin
                        cyc_cnt <= cyc_cnt - 1'b1;
                    end
                end

                StRun: begin
                    if (!enable) begin
                        state     <= StIdle;
                        bit_cnt   <= '0;
                        data      <= '0;
                        busy      <= 1'b0;
                        loop_ctrl <= 1'b1;
                    end else if (cyc_cnt == '0) begin
                        state <= StSample;
                    end else begin
                        cyc_cnt <= cyc_cnt - 1'b1;
                    end
                end

                StSample: begin
                    if (!enable || health_trip) begin
                        // Abort: the partial word never becomes visible as a valid word
                        state     <= StIdle;
                        bit_cnt   <= '0;
                        data      <= '0;
                        busy      <= 1'b0;
                        loop_ctrl <= 1'b1;
                        if (enable) begin
                            seed_tgl <= ~seed_tgl;
                        end
                    end else begin
                        seed_tgl  <= ~seed_tgl;
                        data      <= {data[WORD_BITS-2:0], raw};
                        loop_ctrl <= 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            state <= StDeliver;
                            valid <= 1'b1;
                        end else begin
                            state     <= StSeed;
                            cyc_cnt   <= SEED_LOAD;
                            bit_cnt   <= bit_cnt + 1'b1;
                            loop_seed <= ~seed_tgl;
                        end
                    end
                end

                StDeliver: begin
                    if (ack) begin
                        valid <= 1'b0;
                        if (enable) begin
                            state     <= StSeed;
                            cyc_cnt   <= SEED_LOAD;
                            bit_cnt   <= '0;
                            data      <= '0;
                            loop_seed <= seed_tgl;
                        end else begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state     <= StIdle;
                    busy      <= 1'b0;
                    loop_ctrl <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loop_sampler_ctrl.sv
// Self-checking bench for loop_sampler_ctrl: round-level reference model plus directed scenarios.
module tb_loop_sampler_ctrl;

    localparam int NL = 2;
    localparam int SC = 2;
    localparam int RC = 4;
    localparam int WB = 8;
    localparam int RL = 4;
    localparam int RLEN = SC + RC + 1;

    localparam int M_IDLE = 0;
    localparam int M_ROUND = 1;
    localparam int M_DELIV = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          ack = 1'b0;
    logic [NL-1:0] loop_d = '0;
    logic          loop_ctrl;
    logic          loop_seed;
    logic [WB-1:0] data;
    logic          valid;
    logic          busy;
    logic          error;

    int errors = 0;
    int checks = 0;

    loop_sampler_ctrl #(
        .NUM_LOOPS   (NL),
        .SEED_CYCLES (SC),
        .RUN_CYCLES  (RC),
        .WORD_BITS   (WB),
        .REP_LIMIT   (RL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .ack       (ack),
        .loop_d    (loop_d),
        .loop_ctrl (loop_ctrl),
        .loop_seed (loop_seed),
        .data      (data),
        .valid     (valid),
        .busy      (busy),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Loop stimulus: fixed pattern, or one loop toggling every cycle
    logic [NL-1:0] ld_fix = '0;
    logic          ld_toggle = 1'b0;
    int            cyc_c = 0;

    always @(negedge clk) begin
        cyc_c++;
        loop_d = ld_toggle ? {cyc_c[0], 1'b0} : ld_fix;
    end

    // Reference model: a round is RLEN cycles; the bit sampled at its last cycle is the
    // XOR of loop_d as seen two edges earlier.
    int            m_mode = M_IDLE;
    int            m_pos = 0;
    int            m_nb = 0;
    logic [WB-1:0] m_word = '0;
    logic          m_valid = 1'b0;
    logic          m_seed = 1'b0;
    logic          m_err = 1'b0;
    int            m_run = 0;
    logic          m_last = 1'b0;
    logic [NL-1:0] h1 = '0;
    logic [NL-1:0] h2 = '0;
    logic          r;

    always @(posedge clk) begin
        if (reset) begin
            m_mode = M_IDLE; m_pos = 0; m_nb = 0; m_word = '0; m_valid = 1'b0;
            m_seed = 1'b0; m_err = 1'b0; m_run = 0; m_last = 1'b0; h1 = '0; h2 = '0;
        end else begin
            r = ^h2;
            case (m_mode)
                M_IDLE: if (enable && !m_err) begin
                    m_mode = M_ROUND; m_pos = 0; m_nb = 0; m_word = '0;
                end
                M_ROUND: if (!enable) begin
                    m_mode = M_IDLE; m_nb = 0; m_word = '0;
                end else if (m_pos < RLEN - 1) begin
                    m_pos++;
                end else begin
                    m_seed = !m_seed;
                    m_run = (m_run != 0 && r == m_last) ? m_run + 1 : 1;
                    m_last = r;
`ifdef LOOP_SAMPLER_HEALTH_EN
                    if (m_run >= RL) begin
                        m_err = 1'b1; m_mode = M_IDLE; m_nb = 0; m_word = '0;
                    end else
`endif
                    begin
                        m_word = {m_word[WB-2:0], r};
                        m_nb++;
                        if (m_nb == WB) begin
                            m_mode = M_DELIV; m_valid = 1'b1;
                        end else begin
                            m_pos = 0;
                        end
                    end
                end
                default: if (ack) begin
                    m_valid = 1'b0;
                    if (enable) begin
                        m_mode = M_ROUND; m_pos = 0; m_nb = 0; m_word = '0;
                    end else begin
                        m_mode = M_IDLE;
                    end
                end
            endcase
            h2 = h1;
            h1 = loop_d;
        end
    end

    always @(negedge clk) begin
        check("loop_ctrl", loop_ctrl, (m_mode == M_ROUND && m_pos >= SC) ? 1'b0 : 1'b1);
        check("busy", busy, m_mode != M_IDLE);
        check("valid", valid, m_valid);
        check("error", error, m_err);
        if (m_valid) check("data", data, m_word);
        if (m_mode == M_ROUND && m_pos < SC) check("loop_seed", loop_seed, m_seed);
    end

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int start, input int limit, output int n);
        n = start;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (valid === 1'b1) break;
        end
    endtask

    int            n;
    logic [7:0]    pat;
    logic          saw_valid;

    initial begin
        // 1: alternating raw bits, phase pattern and word latency
        do_reset();
        check("rst_loop_ctrl", loop_ctrl, 1'b1);
        check("rst_data", data, '0);
        ld_toggle = 1'b1;
        enable = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            pat[8-i] = loop_ctrl;
        end
        check("t1_ctrl_pattern", pat, 8'b1100_0001);
        wait_valid(8, 200, n);
        check("t1_valid_latency", n, 57);
        ack = 1'b1; enable = 1'b0;
        @(negedge clk);
        ack = 1'b0;
        repeat (3) @(negedge clk);

`ifndef LOOP_SAMPLER_HEALTH_EN
        // 2: constant raw=1 gives all-ones; valid holds until ack, then next round
        do_reset();
        ld_toggle = 1'b0; ld_fix = 2'b10;
        enable = 1'b1;
        wait_valid(0, 200, n);
        check("t2_data", data, 8'hFF);
        repeat (3) @(negedge clk);
        check("t2_valid_held", valid, 1'b1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("t2_valid_clr", valid, 1'b0);
        check("t2_busy", busy, 1'b1);
        check("t2_seed_ctrl", loop_ctrl, 1'b1);
        enable = 1'b0;
        repeat (2) @(negedge clk);
`endif

        // 3: drop enable during RUN of bit 3, then restart from bit 0
        do_reset();
        ld_toggle = 1'b1;
        enable = 1'b1;
        repeat (24) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("t3_ctrl", loop_ctrl, 1'b1);
        check("t3_busy", busy, 1'b0);
        check("t3_valid", valid, 1'b0);
        enable = 1'b1;
        wait_valid(0, 200, n);
        check("t3_valid_latency", n, 57);
        ack = 1'b1; enable = 1'b0;
        @(negedge clk);
        ack = 1'b0;

`ifndef LOOP_SAMPLER_HEALTH_EN
        // 4: enable dropped while a word waits; word held until ack
        do_reset();
        ld_toggle = 1'b0; ld_fix = 2'b01;
        enable = 1'b1;
        wait_valid(0, 200, n);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        check("t4_valid_held", valid, 1'b1);
        check("t4_data_held", data, 8'hFF);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("t4_busy", busy, 1'b0);
        check("t4_valid", valid, 1'b0);
`endif

        // 5: reset mid-RUN
        do_reset();
        ld_toggle = 1'b1;
        enable = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_ctrl", loop_ctrl, 1'b1);
        check("t5_seed", loop_seed, 1'b0);
        check("t5_data", data, '0);
        check("t5_valid", valid, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_error", error, 1'b0);
        reset = 1'b0; enable = 1'b0;
        @(negedge clk);

        // 6: stuck raw=0
        do_reset();
        ld_toggle = 1'b0; ld_fix = 2'b11;
        enable = 1'b1;
`ifdef LOOP_SAMPLER_HEALTH_EN
        saw_valid = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (valid === 1'b1) saw_valid = 1'b1;
        end
        check("t6_error", error, 1'b1);
        check("t6_busy", busy, 1'b0);
        check("t6_no_valid", saw_valid, 1'b0);
`else
        wait_valid(0, 200, n);
        check("t6_valid_latency", n, 57);
        check("t6_data", data, 8'h00);
        check("t6_error", error, 1'b0);
`endif
        do_reset();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
